rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32×32 register file. Shares the file's single synchronous write port among NREQ producers (ALU, load unit, mul/div) with round-robin arbitration over a valid/ready handshake. Drives the port through registered outputs. Tracks in-flight destination registers so the issue stage can detect RAW hazards on both read operands.

---
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port, with an optional
// RAW-hazard scoreboard compiled in when RF_SCOREBOARD_EN is defined.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [2:0]         gnt_id,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic [AW-1:0]      chk_rs1,
  input  logic [AW-1:0]      chk_rs2,
  output logic               busy1,
  output logic               busy2
);

  logic [2:0]      ptr;
  logic            found;
  logic [2:0]      win_id;
  logic [NREQ-1:0] win_onehot;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            accept;

  // Two passes: requesters at or above ptr first, then wrap around from 0.
  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    found      = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(ptr))) begin
        found         = 1'b1;
        win_id        = 3'(i);
        win_onehot[i] = 1'b1;
        win_addr      = req_addr[i*AW +: AW];
        win_data      = req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found         = 1'b1;
        win_id        = 3'(i);
        win_onehot[i] = 1'b1;
        win_addr      = req_addr[i*AW +: AW];
        win_data      = req_data[i*DW +: DW];
      end
    end
  end

  // The grant is masked by reset so no transfer can be seen while rst_n is low.
  assign req_ready = rst_n ? win_onehot : '0;
  assign accept    = found & rst_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
    end else begin
      // Writes to x0 complete the handshake but never reach the register file.
      rf_we <= accept && (win_addr != '0);
      if (accept) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        gnt_id   <= win_id;
        ptr      <= (win_id == 3'(NREQ-1)) ? 3'd0 : win_id + 3'd1;
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Clear comes from the registered write, i.e. the edge on which the file commits;
  // a same-edge issue to that register is applied last so the new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_waddr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the busy vector is plain flops, not a RAM, so it can and must be cleared
  // by reset; in-flight writes are dropped on reset and nothing would ever clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy1 = busy[chk_rs1];
  assign busy2 = busy[chk_rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter (NREQ=3); scoreboard expectations
// follow whether RF_SCOREBOARD_EN is defined for the build.
module tb_rf_wb_arbiter;

`ifdef RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  gnt_id;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        busy1;
  logic        busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .gnt_id(gnt_id),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_gnt;
    logic        chk_wr;
  } vec_t;

  localparam logic [14:0] ADDR  = {5'd12, 5'd5, 5'd3};
  localparam logic [95:0] DATA  = {32'hC0C0_0002, 32'hDEAD_BEEF, 32'hA0A0_0000};
  localparam logic [14:0] ADDR0 = {5'd12, 5'd5, 5'd0};
  localparam logic [95:0] DATA0 = {32'hC0C0_0002, 32'hDEAD_BEEF, 32'h0000_1234};

  vec_t tbl [13];

  initial begin
    logic [2:0] e_rdy;

    // Rows run back to back from reset; ptr moves as commented.
    tbl[0]  = '{3'b010, ADDR,  DATA,  3'b010, 1'b1, 5'd5,  32'hDEAD_BEEF, 3'd1, 1'b1}; // ptr0 -> 2
    tbl[1]  = '{3'b000, ADDR,  DATA,  3'b000, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd1, 1'b1}; // hold
    tbl[2]  = '{3'b111, ADDR,  DATA,  3'b100, 1'b1, 5'd12, 32'hC0C0_0002, 3'd2, 1'b1}; // -> 0
    tbl[3]  = '{3'b111, ADDR,  DATA,  3'b001, 1'b1, 5'd3,  32'hA0A0_0000, 3'd0, 1'b1}; // -> 1
    tbl[4]  = '{3'b111, ADDR,  DATA,  3'b010, 1'b1, 5'd5,  32'hDEAD_BEEF, 3'd1, 1'b1}; // -> 2
    tbl[5]  = '{3'b111, ADDR,  DATA,  3'b100, 1'b1, 5'd12, 32'hC0C0_0002, 3'd2, 1'b1}; // -> 0
    tbl[6]  = '{3'b001, ADDR0, DATA0, 3'b001, 1'b0, 5'd0,  32'h0,         3'd0, 1'b0}; // x0, -> 1
    tbl[7]  = '{3'b101, ADDR,  DATA,  3'b100, 1'b1, 5'd12, 32'hC0C0_0002, 3'd2, 1'b1}; // -> 0
    tbl[8]  = '{3'b011, ADDR,  DATA,  3'b001, 1'b1, 5'd3,  32'hA0A0_0000, 3'd0, 1'b1}; // -> 1
    tbl[9]  = '{3'b011, ADDR,  DATA,  3'b010, 1'b1, 5'd5,  32'hDEAD_BEEF, 3'd1, 1'b1}; // -> 2
    tbl[10] = '{3'b001, ADDR,  DATA,  3'b001, 1'b1, 5'd3,  32'hA0A0_0000, 3'd0, 1'b1}; // wrap, -> 1
    tbl[11] = '{3'b000, ADDR,  DATA,  3'b000, 1'b0, 5'd3,  32'hA0A0_0000, 3'd0, 1'b1}; // hold
    tbl[12] = '{3'b110, ADDR,  DATA,  3'b010, 1'b1, 5'd5,  32'hDEAD_BEEF, 3'd1, 1'b1}; // -> 2

    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_addr  = ADDR;
    req_data  = DATA;
    iss_valid = 1'b0;
    iss_rd    = '0;
    chk_rs1   = 5'd3;
    chk_rs2   = 5'd5;

    // Reset state, with all requesters valid to show the grant is masked.
    #3;
    check("rst_ready", req_ready, 3'b000);
    check("rst_we",    rf_we,     1'b0);
    check("rst_waddr", rf_waddr,  5'd0);
    check("rst_wdata", rf_wdata,  32'h0);
    check("rst_gnt",   gnt_id,    3'd0);
    check("rst_busy1", busy1,     1'b0);
    check("rst_busy2", busy2,     1'b0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    cyc();

    for (int r = 0; r < 13; r++) begin
      req_valid = tbl[r].valid;
      req_addr  = tbl[r].addr;
      req_data  = tbl[r].data;
      #1;
      check($sformatf("tbl%0d_ready", r), req_ready, tbl[r].exp_ready);
      cyc();
      check($sformatf("tbl%0d_we", r),  rf_we,  tbl[r].exp_we);
      check($sformatf("tbl%0d_gnt", r), gnt_id, tbl[r].exp_gnt);
      if (tbl[r].chk_wr) begin
        check($sformatf("tbl%0d_waddr", r), rf_waddr, tbl[r].exp_waddr);
        check($sformatf("tbl%0d_wdata", r), rf_wdata, tbl[r].exp_wdata);
      end
    end
    req_valid = '0;
    cyc();

    // Fairness from reset: all valid, grants rotate 0,1,2,0,1,2 with rf_we every cycle.
    do_reset();
    req_valid = 3'b111;
    req_addr  = ADDR;
    req_data  = DATA;
    for (int k = 0; k < 6; k++) begin
      e_rdy = 3'b001 << (k % 3);
      #1;
      check($sformatf("fair%0d_ready", k), req_ready, e_rdy);
      cyc();
      check($sformatf("fair%0d_we", k),  rf_we,  1'b1);
      check($sformatf("fair%0d_gnt", k), gnt_id, 3'(k % 3));
    end
    req_valid = '0;

    // Scoreboard set, then clear one cycle after the write reaches the port.
    do_reset();
    chk_rs1   = 5'd7;
    chk_rs2   = 5'd0;
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    check("sb_pre_busy1", busy1, 1'b0);
    cyc();
    iss_valid = 1'b0;
    check("sb_set_busy1", busy1, SB);
    req_valid = 3'b100;
    req_addr  = {5'd7, 5'd5, 5'd3};
    #1;
    check("sb_wr_ready", req_ready, 3'b100);
    cyc();
    req_valid = '0;
    check("sb_wr_we",    rf_we,    1'b1);
    check("sb_wr_waddr", rf_waddr, 5'd7);
    check("sb_wr_busy1", busy1,    SB);
    check("sb_wr_busy2", busy2,    1'b0);
    cyc();
    check("sb_clr_we",    rf_we, 1'b0);
    check("sb_clr_busy1", busy1, 1'b0);
    check("sb_clr_busy2", busy2, 1'b0);

    // Set/clear collision on register 9: the issue wins.
    chk_rs1   = 5'd9;
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    cyc();
    iss_valid = 1'b0;
    check("col_set_busy1", busy1, SB);
    req_valid = 3'b001;
    req_addr  = {5'd12, 5'd5, 5'd9};
    cyc();
    req_valid = '0;
    check("col_we",    rf_we,    1'b1);
    check("col_waddr", rf_waddr, 5'd9);
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    cyc();
    iss_valid = 1'b0;
    check("col_busy1", busy1, SB);
    cyc();
    check("col_hold_busy1", busy1, SB);
    check("col_hold_we",    rf_we, 1'b0);

    // Reset while a write is on the port and busy = 0x0000_0F00.
    for (int rd = 8; rd < 12; rd++) begin
      if (rd != 9) begin
        iss_valid = 1'b1;
        iss_rd    = 5'(rd);
        cyc();
      end
    end
    iss_valid = 1'b0;
    chk_rs1   = 5'd8;
    chk_rs2   = 5'd11;
    check("mid_busy1", busy1, SB);
    check("mid_busy2", busy2, SB);
    req_valid = 3'b010;
    req_addr  = {5'd12, 5'd20, 5'd3};
    cyc();
    check("mid_we", rf_we, 1'b1);
    req_valid = 3'b111;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_we",    rf_we,     1'b0);
    check("mid_rst_busy1", busy1,     1'b0);
    check("mid_rst_busy2", busy2,     1'b0);
    check("mid_rst_ready", req_ready, 3'b000);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 3'b001);
    cyc();
    req_valid = '0;
    check("post_rst_gnt",   gnt_id,   3'd0);
    check("post_rst_we",    rf_we,    1'b1);
    check("post_rst_waddr", rf_waddr, 5'd3);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
